note_capture_pingpong: RTL

Parametrised note-capture engine for the piano datapath. It priority-encodes the live key vector into one byte per sample tick and stores the bytes in two DEPTH-byte ping-pong banks. Each full bank is drained as a sector-sized byte stream with valid/ready handshake to the SD write path. When recording stops, it pads and flushes the partial bank and flags overruns when the drain falls behind capture.

---
 rtl/note_capture_pingpong_if.sv | 28 ++
 rtl/note_capture_pingpong.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/note_capture_pingpong_if.sv
// Sector drain stream from the note-capture engine towards the SD write path.
// The master side produces bytes; the slave side answers with ready.
interface note_capture_pingpong_if;
   logic [7:0] drain_data;
   logic       drain_valid;
   logic       drain_ready;
   logic       drain_last;
   logic       drain_bank;
   logic       sector_done;

   modport master (
      output drain_data,
      output drain_valid,
      output drain_last,
      output drain_bank,
      output sector_done,
      input  drain_ready
   );

   modport slave (
      input  drain_data,
      input  drain_valid,
      input  drain_last,
      input  drain_bank,
      input  sector_done,
      output drain_ready
   );
endinterface

// File: rtl/note_capture_pingpong.sv
// Note-capture engine: priority-encodes keys per sample tick into two ping-pong banks and drains full banks as sectors.
// Optional macro NOTE_CAPTURE_OVR_CNT_EN enables the saturating dropped-sample counter on overrun_cnt.
module note_capture_pingpong #(
   parameter int NUM_KEYS = 12,
   parameter int DEPTH    = 512,
   parameter int OVR_W    = 8
) (
   input  logic                   CLOCK_IO,
   input  logic                   resetn,
   input  logic                   rec_en,
   input  logic                   sample_tick,
   input  logic [NUM_KEYS-1:0]    keys,
   note_capture_pingpong_if.master drain,
   output logic                   overrun,
   output logic [OVR_W-1:0]       overrun_cnt,
   output logic                   busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic [1:0] {D_IDLE, D_FETCH, D_SEND} drain_state_e;

   logic [7:0]    mem_q [0:2*DEPTH-1];
   logic          cap_bank_q, cap_bank_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [1:0]    full_q, full_d;
   logic          pad_q, pad_d;
   logic          rec_q;
   logic          overrun_q;
   logic          busy_q;

   drain_state_e  dstate_q;
   logic          drain_bank_q;
   logic [AW-1:0] rptr_q;
   logic [7:0]    drain_data_q;
   logic          drain_valid_q;
   logic          drain_last_q;
   logic          sector_done_q;

   logic [7:0]    note_code;
   logic [7:0]    cap_wdata;
   logic          cap_we;
   logic          cap_hit;
   logic          ovr_hit;
   logic          drain_release;

   // Lowest asserted key wins, so scan downwards and let the last hit stand.
   always_comb begin
      note_code = 8'h00;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (keys[k]) note_code = 8'(k + 1);
      end
   end

   assign drain_release = (dstate_q == D_SEND) && drain_last_q && drain.drain_ready;
   assign cap_hit       = rec_en && sample_tick && !full_q[cap_bank_q] && !pad_q;
   assign ovr_hit       = rec_en && sample_tick &&  full_q[cap_bank_q] && !pad_q;

   // Capture side: a padding byte and a captured sample share the single write port.
   always_comb begin
      cap_bank_d = cap_bank_q;
      wptr_d     = wptr_q;
      full_d     = full_q;
      pad_d      = pad_q;
      cap_we     = 1'b0;
      cap_wdata  = note_code;
      if (drain_release) full_d[drain_bank_q] = 1'b0;
      if (pad_q || cap_hit) begin
         cap_we = 1'b1;
         if (pad_q) cap_wdata = 8'hFF;
         if (wptr_q == LAST_IDX) begin
            full_d[cap_bank_q] = 1'b1;
            cap_bank_d         = ~cap_bank_q;
            wptr_d             = '0;
            pad_d              = 1'b0;
         end else begin
            wptr_d = wptr_q + 1'b1;
         end
      end else if (rec_q && !rec_en && (wptr_q != '0)) begin
         pad_d = 1'b1;
      end
   end

   always_ff @(posedge CLOCK_IO) begin
      if (cap_we) mem_q[{cap_bank_q, wptr_q}] <= cap_wdata;
   end

   always_ff @(posedge CLOCK_IO or negedge resetn) begin
      if (!resetn) begin
         cap_bank_q <= 1'b0;
         wptr_q     <= '0;
         full_q     <= 2'b00;
         pad_q      <= 1'b0;
         rec_q      <= 1'b0;
         overrun_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         cap_bank_q <= cap_bank_d;
         wptr_q     <= wptr_d;
         full_q     <= full_d;
         pad_q      <= pad_d;
         rec_q      <= rec_en;
         overrun_q  <= overrun_q | ovr_hit;
         busy_q     <= (|full_d) | pad_d;
      end
   end

`ifdef NOTE_CAPTURE_OVR_CNT_EN
   logic [OVR_W-1:0] ovr_cnt_q;

   always_ff @(posedge CLOCK_IO or negedge resetn) begin
      if (!resetn) begin
         ovr_cnt_q <= '0;
      end else if (ovr_hit && (ovr_cnt_q != '1)) begin
         ovr_cnt_q <= ovr_cnt_q + 1'b1;
      end
   end

   assign overrun_cnt = ovr_cnt_q;
`else
   assign overrun_cnt = '0;
`endif

   // Drain reads one byte ahead so that ready held high yields a byte every cycle.
   always_ff @(posedge CLOCK_IO or negedge resetn) begin
      if (!resetn) begin
         dstate_q      <= D_IDLE;
         drain_bank_q  <= 1'b0;
         rptr_q        <= '0;
         drain_data_q  <= 8'h00;
         drain_valid_q <= 1'b0;
         drain_last_q  <= 1'b0;
         sector_done_q <= 1'b0;
      end else begin
         sector_done_q <= 1'b0;
         case (dstate_q)
            D_IDLE: begin
               if (full_q[drain_bank_q]) begin
                  rptr_q   <= '0;
                  dstate_q <= D_FETCH;
               end
            end
            D_FETCH: begin
               drain_data_q  <= mem_q[{drain_bank_q, rptr_q}];
               drain_last_q  <= (rptr_q == LAST_IDX);
               rptr_q        <= rptr_q + 1'b1;
               drain_valid_q <= 1'b1;
               dstate_q      <= D_SEND;
            end
            D_SEND: begin
               if (drain.drain_ready) begin
                  if (drain_last_q) begin
                     drain_data_q  <= 8'h00;
                     drain_valid_q <= 1'b0;
                     drain_last_q  <= 1'b0;
                     sector_done_q <= 1'b1;
                     drain_bank_q  <= ~drain_bank_q;
                     dstate_q      <= D_IDLE;
                  end else begin
                     drain_data_q <= mem_q[{drain_bank_q, rptr_q}];
                     drain_last_q <= (rptr_q == LAST_IDX);
                     rptr_q       <= rptr_q + 1'b1;
                  end
               end
            end
            default: dstate_q <= D_IDLE;
         endcase
      end
   end

   assign drain.drain_data  = drain_data_q;
   assign drain.drain_valid = drain_valid_q;
   assign drain.drain_last  = drain_last_q;
   assign drain.drain_bank  = drain_bank_q;
   assign drain.sector_done = sector_done_q;
   assign overrun           = overrun_q;
   assign busy              = busy_q;
endmodule
